// File: rtl/acq_peak_detect.sv
// Acquisition peak detector: tracks the highest |I|+|Q| over a code-phase sweep
// and a non-adjacent runner-up, then issues the acquire/no-acquire decision.
//
// state  | meaning
// IDLE   | waiting for acq_start; correlation input ignored
// SWEEP  | accepting correlation results until the corr_last beat
// DRAIN  | two cycles for the magnitude pipeline to empty
// DECIDE | ratio test; result registers loaded
// DONE   | single-cycle acq_done, back to IDLE

module acq_peak_detect #(
    parameter int CORR_WIDTH    = 32,
    parameter int PRN_PHS_WIDTH = 12,
    parameter int NUM_PHS       = 4092,
    parameter int THR_WIDTH     = 5
) (
    input  logic                            rx_clk,
    input  logic                            rx_rst,
    input  logic                            acq_start,
    input  logic [THR_WIDTH-1:0]            thr_ratio,
    input  logic                            corr_vld,
    input  logic signed [CORR_WIDTH-1:0]    corr_i,
    input  logic signed [CORR_WIDTH-1:0]    corr_q,
    input  logic [PRN_PHS_WIDTH-1:0]        corr_phs,
    input  logic                            corr_last,
    output logic                            acq_busy,
    output logic                            acq_done,
    output logic                            acq_hit,
    output logic [PRN_PHS_WIDTH-1:0]        acq_prn_phs,
    output logic [CORR_WIDTH:0]             acq_peak,
    output logic [CORR_WIDTH:0]             acq_second
);

    localparam int MAG_W  = CORR_WIDTH + 1;
    localparam int PROD_W = MAG_W + THR_WIDTH;
    localparam logic [PRN_PHS_WIDTH-1:0] PHS_LAST = PRN_PHS_WIDTH'(NUM_PHS - 1);
    localparam logic [PRN_PHS_WIDTH:0]   PHS_ONE  = 1;
    localparam logic [CORR_WIDTH-1:0]    ABS_ONE  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DECIDE,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic                     drain_cnt;
    logic [THR_WIDTH-1:0]     thr_lat;
    logic                     s1_vld;
    logic [CORR_WIDTH-1:0]    s1_abs_i, s1_abs_q;
    logic [PRN_PHS_WIDTH-1:0] s1_phs;
    logic [MAG_W-1:0]         peak, second;
    logic [PRN_PHS_WIDTH-1:0] peak_phs;

    logic [MAG_W-1:0]  mag;
    logic              near_peak;
    logic [PROD_W-1:0] dec_lhs, dec_rhs;
    logic              dec_hit;
    logic              take_beat;

    // Two's-complement negate in unsigned space keeps |most-negative| exact.
    function automatic logic [CORR_WIDTH-1:0] abs_val(input logic [CORR_WIDTH-1:0] x);
        return x[CORR_WIDTH-1] ? (~x + ABS_ONE) : x;
    endfunction

    function automatic logic is_adj(input logic [PRN_PHS_WIDTH-1:0] a,
                                    input logic [PRN_PHS_WIDTH-1:0] b);
        logic [PRN_PHS_WIDTH:0] ae, be;
        ae = {1'b0, a};
        be = {1'b0, b};
        return (ae == be) || (ae == be + PHS_ONE) || (be == ae + PHS_ONE) ||
               ((a == '0) && (b == PHS_LAST)) || ((a == PHS_LAST) && (b == '0));
    endfunction

    assign take_beat = corr_vld && (state == ST_SWEEP);
    assign mag       = {1'b0, s1_abs_i} + {1'b0, s1_abs_q};
    assign near_peak = is_adj(s1_phs, peak_phs);
    assign dec_lhs   = PROD_W'(peak) << 3;
    assign dec_rhs   = PROD_W'(second) * PROD_W'(thr_lat);
    assign dec_hit   = (dec_lhs >= dec_rhs) && (peak != '0);

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acq_busy  = 1'b1;
        acq_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                acq_busy = 1'b0;
                if (acq_start) state_nxt = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (corr_vld && corr_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == 1'b0) state_nxt = ST_DECIDE;
            end
            ST_DECIDE: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                acq_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            drain_cnt   <= 1'b0;
            thr_lat     <= '0;
            s1_vld      <= 1'b0;
            s1_abs_i    <= '0;
            s1_abs_q    <= '0;
            s1_phs      <= '0;
            peak        <= '0;
            second      <= '0;
            peak_phs    <= '0;
            acq_hit     <= 1'b0;
            acq_prn_phs <= '0;
            acq_peak    <= '0;
            acq_second  <= '0;
        end else begin
            s1_vld <= take_beat;
            if (take_beat) begin
                s1_abs_i <= abs_val(corr_i);
                s1_abs_q <= abs_val(corr_q);
                s1_phs   <= corr_phs;
            end

            if (state == ST_SWEEP) begin
                drain_cnt <= 1'b1;
            end else if ((state == ST_DRAIN) && (drain_cnt != 1'b0)) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            if ((state == ST_IDLE) && acq_start) begin
                peak        <= '0;
                second      <= '0;
                peak_phs    <= '0;
                thr_lat     <= thr_ratio;
                acq_hit     <= 1'b0;
                acq_prn_phs <= '0;
            end else if (s1_vld) begin
                // Strict compares keep the earlier phase on ties.
                if (mag > peak) begin
                    peak     <= mag;
                    peak_phs <= s1_phs;
                    if (!near_peak) second <= peak;
                end else if (!near_peak && (mag > second)) begin
                    second <= mag;
                end
            end

            if (state == ST_DECIDE) begin
                acq_hit     <= dec_hit;
                acq_prn_phs <= peak_phs;
                acq_peak    <= peak;
                acq_second  <= second;
            end
        end
    end

endmodule

// File: tb/tb_acq_peak_detect.sv
// Bench for acq_peak_detect: directed sweeps plus randomized sweeps, scored
// against a behavioural reference of the peak/second rules.

module tb_acq_peak_detect;

    localparam int CW = 32;
    localparam int PW = 12;
    localparam int NP = 4092;
    localparam int TW = 5;

    typedef struct {
        longint i;
        longint q;
        int     phs;
    } beat_t;

    typedef struct {
        bit     hit;
        int     phs;
        longint peak;
        longint second;
        longint done_cyc;
    } exp_t;

    logic                 rx_clk = 1'b0;
    logic                 rx_rst = 1'b1;
    logic                 acq_start = 1'b0;
    logic [TW-1:0]        thr_ratio = '0;
    logic                 corr_vld = 1'b0;
    logic signed [CW-1:0] corr_i = '0;
    logic signed [CW-1:0] corr_q = '0;
    logic [PW-1:0]        corr_phs = '0;
    logic                 corr_last = 1'b0;
    logic                 acq_busy;
    logic                 acq_done;
    logic                 acq_hit;
    logic [PW-1:0]        acq_prn_phs;
    logic [CW:0]          acq_peak;
    logic [CW:0]          acq_second;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    beat_t  beats[$];
    exp_t   sb[$];
    exp_t   mon_e;
    int     model_thr = 0;
    longint big = 64'd2147483648;

    acq_peak_detect #(
        .CORR_WIDTH(CW), .PRN_PHS_WIDTH(PW), .NUM_PHS(NP), .THR_WIDTH(TW)
    ) dut (
        .rx_clk(rx_clk), .rx_rst(rx_rst), .acq_start(acq_start), .thr_ratio(thr_ratio),
        .corr_vld(corr_vld), .corr_i(corr_i), .corr_q(corr_q), .corr_phs(corr_phs),
        .corr_last(corr_last), .acq_busy(acq_busy), .acq_done(acq_done),
        .acq_hit(acq_hit), .acq_prn_phs(acq_prn_phs), .acq_peak(acq_peak),
        .acq_second(acq_second)
    );

    always #5 rx_clk = ~rx_clk;

    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint abs_l(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic bit near(input int a, input int b);
        int d;
        d = a - b;
        return (d >= -1 && d <= 1) || (a == 0 && b == NP - 1) || (a == NP - 1 && b == 0);
    endfunction

    // Reference decision computed from the whole list of results in the sweep.
    function automatic exp_t ref_decide();
        exp_t   e;
        longint pk, sc, m;
        int     pp;
        pk = 0; sc = 0; pp = 0;
        foreach (beats[k]) begin
            m = abs_l(beats[k].i) + abs_l(beats[k].q);
            if (m > pk) begin
                if (!near(beats[k].phs, pp)) sc = pk;
                pk = m;
                pp = beats[k].phs;
            end else if (!near(beats[k].phs, pp) && m > sc) begin
                sc = m;
            end
        end
        e.hit      = (pk != 0) && (pk * 8 >= sc * model_thr);
        e.phs      = pp;
        e.peak     = pk;
        e.second   = sc;
        e.done_cyc = 0;
        return e;
    endfunction

    always @(negedge rx_clk) begin
        if (!rx_rst && acq_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got acq_done=1, required 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_latency", cyc, mon_e.done_cyc);
                check("acq_hit", longint'(acq_hit), longint'(mon_e.hit));
                check("acq_prn_phs", longint'(acq_prn_phs), longint'(mon_e.phs));
                check("acq_peak", longint'(acq_peak), mon_e.peak);
                check("acq_second", longint'(acq_second), mon_e.second);
            end
        end
    end

    task automatic gap();
        @(posedge rx_clk); #1;
        acq_start = 1'b0;
        corr_vld  = 1'b0;
        corr_last = 1'b0;
    endtask

    task automatic start_sweep(input int thr);
        @(posedge rx_clk); #1;
        acq_start = 1'b1;
        corr_vld  = 1'b0;
        corr_last = 1'b0;
        thr_ratio = thr[TW-1:0];
        model_thr = thr;
        beats.delete();
    endtask

    task automatic send_beat(input longint i, input longint q, input int phs,
                             input bit last, input bit stray);
        beat_t b;
        exp_t  e;
        @(posedge rx_clk); #1;
        acq_start = stray;
        if (stray) thr_ratio = '0;
        corr_vld  = 1'b1;
        corr_i    = i[CW-1:0];
        corr_q    = q[CW-1:0];
        corr_phs  = phs[PW-1:0];
        corr_last = last;
        b.i = i; b.q = q; b.phs = phs;
        beats.push_back(b);
        if (last) begin
            e = ref_decide();
            e.done_cyc = cyc + 4;
            sb.push_back(e);
        end
    endtask

    task automatic finish_sweep();
        int n;
        gap();
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge rx_clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: got no acq_done, required one within 30 cycles");
            sb.delete();
        end
        @(posedge rx_clk); #2;
        check("busy_after_done", longint'(acq_busy), 0);
    endtask

    task automatic idle_noise(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge rx_clk); #1;
            acq_start = 1'b0;
            corr_vld  = 1'b1;
            corr_i    = -32'sd2000000;
            corr_q    = 32'sd1999999;
            corr_phs  = PW'(k);
            corr_last = k[0];
        end
        gap();
        repeat (8) @(negedge rx_clk);
    endtask

    task automatic check_held(input string tag, input longint hit, input longint phs,
                              input longint pk, input longint sc);
        check({tag, "_hit"}, longint'(acq_hit), hit);
        check({tag, "_phs"}, longint'(acq_prn_phs), phs);
        check({tag, "_peak"}, longint'(acq_peak), pk);
        check({tag, "_second"}, longint'(acq_second), sc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no summary, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     thr, len, mode, start, phs;
        longint a, i, q;
        bit     stray;

        repeat (3) @(posedge rx_clk);
        #1 rx_rst = 1'b0;
        @(negedge rx_clk);
        check("rst_busy", longint'(acq_busy), 0);
        check("rst_done", longint'(acq_done), 0);
        check_held("rst", 0, 0, 0, 0);

        idle_noise(10);
        check("idle_noise_busy", longint'(acq_busy), 0);
        check_held("idle_noise", 0, 0, 0, 0);

        start_sweep(16);
        for (int p = 0; p < NP; p++) begin
            if (p == 1234) send_beat(-3000, 2000, p, 1'b0, 1'b0);
            else send_beat(100, -50, p, p == NP - 1, 1'b0);
        end
        finish_sweep();
        check_held("strong", 1, 1234, 5000, 150);

        idle_noise(12);
        check_held("held_after_idle", 1, 1234, 5000, 150);

        start_sweep(16);
        for (int p = 0; p < 100; p++) send_beat(p * 7, -p, p, 1'b0, 1'b0);
        @(posedge rx_clk); #1;
        corr_vld = 1'b0;
        rx_rst   = 1'b1;
        @(posedge rx_clk); #1;
        rx_rst = 1'b0;
        @(negedge rx_clk);
        check("midrst_busy", longint'(acq_busy), 0);
        check("midrst_done", longint'(acq_done), 0);
        check_held("midrst", 0, 0, 0, 0);
        repeat (10) @(negedge rx_clk);
        beats.delete();

        start_sweep(16);
        for (int p = 0; p < 600; p++) begin
            if (p == 9) send_beat(1000, 0, p, 1'b0, 1'b0);
            else if (p == 10) send_beat(-900, 0, p, 1'b0, 1'b0);
            else if (p == 500) send_beat(0, 400, p, 1'b0, 1'b0);
            else send_beat(5, -5, p, p == 599, 1'b0);
        end
        finish_sweep();
        check_held("adjacent", 1, 9, 1000, 400);

        start_sweep(16);
        for (int p = 0; p < NP; p++) begin
            if (p == 0) send_beat(400, -400, p, 1'b0, 1'b0);
            else if (p == 2000) send_beat(-150, 150, p, 1'b0, 1'b0);
            else if (p == NP - 1) send_beat(700, 0, p, 1'b1, 1'b0);
            else send_beat(5, 5, p, 1'b0, 1'b0);
        end
        finish_sweep();
        check_held("wrap", 1, 0, 800, 300);

        start_sweep(16);
        for (int p = 0; p < 400; p++) begin
            if (p == 100) send_beat(1000, 0, p, 1'b0, 1'b0);
            else if (p == 300) send_beat(0, -700, p, 1'b0, 1'b0);
            else send_beat(5, -5, p, p == 399, p == 200);
        end
        finish_sweep();
        check_held("nohit", 0, 100, 1000, 700);

        start_sweep(31);
        for (int p = 0; p < 20; p++) begin
            if (p == 5) send_beat(-big, -big, p, 1'b0, 1'b0);
            else if (p == 15) send_beat(-big, big - 1, p, 1'b0, 1'b0);
            else send_beat(1, 1, p, p == 19, 1'b0);
        end
        finish_sweep();
        check_held("extreme", 0, 5, 64'd4294967296, 64'd4294967295);

        for (int r = 0; r < 6; r++) begin
            thr   = $urandom_range(0, 31);
            len   = $urandom_range(20, 300);
            mode  = r % 3;
            start = $urandom_range(0, 4095);
            a     = (mode == 0) ? 20 : 100000;
            start_sweep(thr);
            for (int n = 0; n < len; n++) begin
                if ($urandom_range(0, 3) == 0) gap();
                if (mode == 2) begin
                    i = longint'(int'($urandom()));
                    q = longint'(int'($urandom()));
                end else begin
                    i = longint'($urandom_range(0, 2 * a)) - a;
                    q = longint'($urandom_range(0, 2 * a)) - a;
                end
                if (mode == 0) phs = (start + n) % 4096;
                else phs = $urandom_range(0, 4095);
                stray = ($urandom_range(0, 15) == 0);
                send_beat(i, q, phs, n == len - 1, stray);
            end
            finish_sweep();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_peak_detect.md
Name: acq_peak_detect

Overview:
- Downstream of the correlation accumulator in the B1 acquisition chain.
- Consumes one accumulated I/Q correlation result per PRN code phase during a phase sweep.
- Computes the magnitude of each result and tracks the highest peak and a non-adjacent second peak.
- At sweep end, issues an acquire/no-acquire decision with the winning code phase, for the tracking-loop handover logic.

Parameters:
- CORR_WIDTH, 32, width of signed accumulated I and Q inputs.
- PRN_PHS_WIDTH, 12, width of the code-phase index.
- NUM_PHS, 4092, phases per sweep (2046 chips x 2 samples); phase indices are 0..NUM_PHS-1.
- THR_WIDTH, 5, width of the ratio threshold, in units of 1/8.

Ports:
- rx_clk  in  1  clock.
- rx_rst  in  1  synchronous active-high reset.
- acq_start  in  1  single-cycle pulse; arms a new sweep.
- thr_ratio  in  THR_WIDTH  peak/second ratio threshold x8; sampled on acq_start.
- corr_vld  in  1  corr_i/corr_q/corr_phs valid this cycle.
- corr_i  in  CORR_WIDTH  signed in-phase accumulation.
- corr_q  in  CORR_WIDTH  signed quadrature accumulation.
- corr_phs  in  PRN_PHS_WIDTH  code phase of this result.
- corr_last  in  1  qualifies the final result of the sweep; valid only with corr_vld.
- acq_busy  out  1  high from acq_start until acq_done.
- acq_done  out  1  single-cycle pulse when the decision is valid.
- acq_hit  out  1  decision; held until the next acq_start.
- acq_prn_phs  out  PRN_PHS_WIDTH  phase of the highest peak; held.
- acq_peak  out  CORR_WIDTH+1  highest magnitude; held.
- acq_second  out  CORR_WIDTH+1  second magnitude; held.

Behaviour:
- Reset: all outputs and internal registers are 0; FSM enters IDLE.
- Reset mid-sweep aborts the sweep with no acq_done.

FSM:
- IDLE: acq_busy=0. acq_start moves to SWEEP, clears peak, second and acq_prn_phs, latches thr_ratio, and clears acq_hit. corr_vld is ignored in IDLE.
- SWEEP: acq_busy=1. Each corr_vld goes through a 2-stage pipeline: stage 1 registers |I| and |Q|; stage 2 registers mag=|I|+|Q| (CORR_WIDTH+1 bits, unsigned, no saturation) and updates peak/second. A corr_vld with corr_last moves to DRAIN. acq_start in SWEEP is ignored.
- DRAIN: waits 2 cycles for the pipeline to empty, then moves to DECIDE.
- DECIDE: one cycle. Computes acq_hit = (peak*8 >= second*thr_ratio) && (peak != 0) at full product width. Registers acq_hit, acq_peak, acq_second and acq_prn_phs. Moves to DONE.
- DONE: acq_done=1 for exactly one cycle, then moves to IDLE.
- acq_done occurs 4 cycles after the corr_last beat.

Absolute value:
- |most-negative| = 2^(CORR_WIDTH-1), represented exactly in CORR_WIDTH bits unsigned.

Peak update rule (stage 2), with adj(a,b) true when the circular distance between a and b is <=1 mod NUM_PHS (0 and NUM_PHS-1 are adjacent):
- If mag > peak: peak<=mag and peak_phs<=phs. If !adj(phs, old peak_phs), then second<=old peak; otherwise second is unchanged.
- Else if !adj(phs, peak_phs) and mag > second: second<=mag.
- Ties (mag == peak) keep the earlier phase.
- The first valid result always becomes the peak (peak starts at 0, mag>0), except that an all-zero result leaves peak at 0 and phase at 0.

Sweep length and out-of-range input:
- Sweep length is set by corr_last, not counted; fewer or more than NUM_PHS results are legal.
- corr_phs >= NUM_PHS is processed as given; adjacency uses raw arithmetic, with wrap only between 0 and NUM_PHS-1.
- thr_ratio=0 forces a hit whenever peak != 0.

Test Plan:
- Reset mid-sweep: start, feed 100 results, assert rx_rst -> acq_busy=0, no acq_done, all outputs 0; a fresh sweep then completes normally.
- Single strong peak: 4092 results with I=100, Q=-50, except phase 1234 with I=-3000, Q=2000, and the last beat flagged; thr_ratio=16 -> acq_done 4 cycles after the last beat, acq_hit=1, acq_prn_phs=1234, acq_peak=5000, acq_second=150.
- Adjacent exclusion: mags 1000@phase 9, 900@phase 10, 400@phase 500, rest 10 -> peak=1000@9, second=400, since 900 is adjacent and excluded.
- Circular wrap: peak 800@phase 0, 700@phase 4091, 300@phase 2000 -> second=300.
- No hit: peak 1000, second 700, thr_ratio=16 -> 8000 < 11200, acq_hit=0, acq_prn_phs still reports the peak phase.
- Extremes and ignored inputs:
  - I=Q=-2^31 -> mag=2^32, with no overflow in the compare.
  - acq_start during SWEEP is ignored.
  - corr_vld in IDLE has no effect.
